// File: rtl/dmem_arbiter_if.sv
// Request, response and DataMem signals shared by the two requesters, the arbiter
// and the data memory. The slave modport is the arbiter's view of the bus.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              i_p0_req;
  logic              i_p0_we;
  logic [ADDR_W-1:0] i_p0_addr;
  logic [DATA_W-1:0] i_p0_wdata;
  logic [3:0]        i_p0_bmask;
  logic              o_p0_gnt;
  logic              o_p0_rvalid;
  logic [DATA_W-1:0] o_p0_rdata;
  logic              o_p0_err;

  logic              i_p1_req;
  logic              i_p1_we;
  logic [ADDR_W-1:0] i_p1_addr;
  logic [DATA_W-1:0] i_p1_wdata;
  logic [3:0]        i_p1_bmask;
  logic              o_p1_gnt;
  logic              o_p1_rvalid;
  logic [DATA_W-1:0] o_p1_rdata;
  logic              o_p1_err;

  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata, i_p0_bmask,
    output o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
    input  i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, i_p1_bmask,
    output o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
    output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
    input  i_mem_rdata
  );

  modport master (
    output i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata, i_p0_bmask,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
    output i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, i_p1_bmask,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
    input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single DataMem port: grant selection, alignment checks,
// write suppression on illegal accesses and a registered one-cycle response per port.
module dmem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  typedef struct packed {
    logic              rvalid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  port_e             last_q, last_d;
  logic [3:0]        wait_q, wait_d;
  rsp_t              rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic              gnt0, gnt1, p1_wins;
  logic              legal0, legal1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_bmask;
  logic              mem_wren;

  function automatic logic access_legal(input logic [3:0] bmask, input logic [1:0] lsb);
    case (bmask)
      4'b0001: access_legal = 1'b1;
      4'b0011: access_legal = ~lsb[0];
      4'b1111: access_legal = (lsb == 2'b00);
      default: access_legal = 1'b0;
    endcase
  endfunction

  assign legal0 = access_legal(bus.i_p0_bmask, bus.i_p0_addr[1:0]);
  assign legal1 = access_legal(bus.i_p1_bmask, bus.i_p1_addr[1:0]);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    p1_wins = (FIXED_PRIO != 0) ? (wait_q == WAIT_MAX) : (last_q == PORT0);
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!i_reset) begin
      if (bus.i_p0_req && bus.i_p1_req) begin
        gnt0 = ~p1_wins;
        gnt1 = p1_wins;
      end else begin
        gnt0 = bus.i_p0_req;
        gnt1 = bus.i_p1_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_bmask = '0;
    mem_wren  = 1'b0;
    if (gnt0) begin
      mem_addr  = bus.i_p0_addr;
      mem_wdata = bus.i_p0_wdata;
      mem_bmask = bus.i_p0_bmask;
      mem_wren  = bus.i_p0_we & legal0;
    end else if (gnt1) begin
      mem_addr  = bus.i_p1_addr;
      mem_wdata = bus.i_p1_wdata;
      mem_bmask = bus.i_p1_bmask;
      mem_wren  = bus.i_p1_we & legal1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = PORT0;
    else if (gnt1) last_d = PORT1;

    // Starvation guard: counts cycles port 1 asks and loses, cleared once it wins or leaves.
    wait_d = '0;
    if ((FIXED_PRIO != 0) && bus.i_p1_req && !gnt1)
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 4'd1;

    rsp0_d.rvalid = gnt0;
    rsp0_d.err    = gnt0 & ~legal0;
    rsp0_d.rdata  = (gnt0 && legal0 && !bus.i_p0_we) ? bus.i_mem_rdata : '0;
    rsp1_d.rvalid = gnt1;
    rsp1_d.err    = gnt1 & ~legal1;
    rsp1_d.rdata  = (gnt1 && legal1 && !bus.i_p1_we) ? bus.i_mem_rdata : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q <= PORT1;
      wait_q <= '0;
      rsp0_q <= '0;
      rsp1_q <= '0;
    end else begin
      last_q <= last_d;
      wait_q <= wait_d;
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
    end
  end

  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_bmask = mem_bmask;
  assign bus.o_mem_wren  = mem_wren;

  assign bus.o_p0_gnt = gnt0;
  assign bus.o_p1_gnt = gnt1;

  // A response captured in the cycle before reset is discarded, not presented.
  assign bus.o_p0_rvalid = rsp0_q.rvalid & ~i_reset;
  assign bus.o_p0_err    = rsp0_q.err & ~i_reset;
  assign bus.o_p0_rdata  = i_reset ? '0 : rsp0_q.rdata;
  assign bus.o_p1_rvalid = rsp1_q.rvalid & ~i_reset;
  assign bus.o_p1_err    = rsp1_q.err & ~i_reset;
  assign bus.o_p1_rdata  = i_reset ? '0 : rsp1_q.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with its own
// DataMem, compared every cycle against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 512;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } rq_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata1;
    logic [31:0] rdata0;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren;
  } view_t;

  typedef struct {
    bit          rvalid;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  rq_t   drv [2][2];
  view_t obs [2];
  int    checks = 0;
  int    errors = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  int          m_last [2];
  int          m_wait [2];
  rsp_t        m_rsp  [2][2];
  logic [31:0] m_mem  [2][WORDS];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic [31:0] dm [WORDS];
    logic [3:0]  lanes;

    dmem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(g), .MAX_WAIT(MAX_WAIT)
    ) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus)
    );

    assign bus.i_p0_req   = drv[g][0].req;
    assign bus.i_p0_we    = drv[g][0].we;
    assign bus.i_p0_addr  = drv[g][0].addr;
    assign bus.i_p0_wdata = drv[g][0].wdata;
    assign bus.i_p0_bmask = drv[g][0].bmask;
    assign bus.i_p1_req   = drv[g][1].req;
    assign bus.i_p1_we    = drv[g][1].we;
    assign bus.i_p1_addr  = drv[g][1].addr;
    assign bus.i_p1_wdata = drv[g][1].wdata;
    assign bus.i_p1_bmask = drv[g][1].bmask;

    // DataMem stand-in: byte lanes start at addr[1:0], combinational read, 0 while writing.
    assign lanes = 4'(bus.o_mem_bmask << bus.o_mem_addr[1:0]);
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < WORDS; i++) dm[i] <= '0;
      end else if (bus.o_mem_wren) begin
        for (int k = 0; k < 4; k++)
          if (lanes[k]) dm[bus.o_mem_addr[10:2]][8*k +: 8] <= bus.o_mem_wdata[8*k +: 8];
      end
    end
    assign bus.i_mem_rdata = bus.o_mem_wren ? '0 : dm[bus.o_mem_addr[10:2]];

    assign obs[g] = {bus.o_p1_gnt, bus.o_p0_gnt, bus.o_p1_rvalid, bus.o_p0_rvalid,
                     bus.o_p1_err, bus.o_p0_err, bus.o_p1_rdata, bus.o_p0_rdata,
                     bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask, bus.o_mem_wren};
  end

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [3:0] m, input logic [10:0] a);
    return (m == 4'b0001) || (m == 4'b0011 && a % 2 == 0) || (m == 4'b1111 && a % 4 == 0);
  endfunction

  function automatic int winner(input int d);
    bit r0 = drv[d][0].req;
    bit r1 = drv[d][1].req;
    if (rst) return -1;
    if (r0 && r1) begin
      if (d == 1) return (m_wait[d] >= MAX_WAIT) ? 1 : 0;
      return 1 - m_last[d];
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic view_t model_view(input int d);
    view_t v = '0;
    int    w = winner(d);
    if (w >= 0) begin
      v.gnt[w]     = 1'b1;
      v.mem_addr   = drv[d][w].addr;
      v.mem_wdata  = drv[d][w].wdata;
      v.mem_bmask  = drv[d][w].bmask;
      v.mem_wren   = drv[d][w].we && legal(drv[d][w].bmask, drv[d][w].addr);
    end
    if (!rst) begin
      v.rvalid = {m_rsp[d][1].rvalid, m_rsp[d][0].rvalid};
      v.err    = {m_rsp[d][1].err, m_rsp[d][0].err};
      v.rdata0 = m_rsp[d][0].rdata;
      v.rdata1 = m_rsp[d][1].rdata;
    end
    return v;
  endfunction

  function automatic void model_tick(input int d);
    int  w = winner(d);
    rq_t q;
    bit  ok;
    int  nbytes;
    int  ba;
    if (rst) begin
      m_last[d] = 1;
      m_wait[d] = 0;
      for (int p = 0; p < 2; p++) m_rsp[d][p] = '{rvalid: 0, err: 0, rdata: '0};
      for (int i = 0; i < WORDS; i++) m_mem[d][i] = '0;
      return;
    end
    for (int p = 0; p < 2; p++) m_rsp[d][p] = '{rvalid: 0, err: 0, rdata: '0};
    if (w >= 0) begin
      q  = drv[d][w];
      ok = legal(q.bmask, q.addr);
      m_rsp[d][w].rvalid = 1;
      m_rsp[d][w].err    = !ok;
      m_rsp[d][w].rdata  = (ok && !q.we) ? m_mem[d][q.addr / 4] : 32'h0;
      if (ok && q.we) begin
        nbytes = (q.bmask == 4'b1111) ? 4 : (q.bmask == 4'b0011) ? 2 : 1;
        for (int i = 0; i < nbytes; i++) begin
          ba = int'(q.addr) + i;
          m_mem[d][ba / 4][8*(ba % 4) +: 8] = q.wdata[8*(ba % 4) +: 8];
        end
      end
      m_last[d] = w;
    end
    if (drv[d][1].req && w != 1) m_wait[d] = (m_wait[d] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[d] + 1;
    else m_wait[d] = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int d, input int p, input bit we, input logic [10:0] a,
                         input logic [31:0] data, input logic [3:0] m);
    drv[d][p] = '{req: 1'b1, we: we, addr: a, wdata: data, bmask: m};
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) drv[d][p] = '0;
  endtask

  function automatic rq_t rand_req();
    rq_t r;
    r.req   = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 11'($urandom_range(0, 31));
    r.wdata = $urandom;
    case ($urandom_range(0, 4))
      0:       r.bmask = 4'b0001;
      1:       r.bmask = 4'b0011;
      2, 3:    r.bmask = 4'b1111;
      default: r.bmask = 4'($urandom_range(0, 15));
    endcase
    return r;
  endfunction

  task automatic advance();
    for (int d = 0; d < 2; d++) model_tick(d);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    view_t exp_v;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 11'h000, 32'h0, 4'b1111);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== '0) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got %h want all zero", d, obs[d]);
      end
    end
    advance();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_v = model_view(d);
      checks++;
      if (obs[d] !== exp_v) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %h want %h", d, obs[d], exp_v);
      end
      checks++;
      if (obs[d].gnt !== 2'b01) begin
        errors++;
        $display("FAIL first_conflict_p0 dut%0d: gnt %b want 01", d, obs[d].gnt);
      end
    end
    advance();
    idle_all();
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_v = model_view(d);
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL reset_drain dut%0d: got %h want %h", d, obs[d], exp_v);
        end
      end
      advance();
    end
  endtask

  task automatic test_store_load();
    view_t exp_v;
    for (int step = 0; step < 3; step++) begin
      idle_all();
      for (int d = 0; d < 2; d++) begin
        if (step == 0) set_req(d, 0, 1'b1, 11'h00C, 32'hDEADBEEF, 4'b1111);
        if (step == 1) set_req(d, 1, 1'b0, 11'h00C, 32'h0, 4'b1111);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_v = model_view(d);
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL store_load step%0d dut%0d: got %h want %h", step, d, obs[d], exp_v);
        end
        if (step == 2) begin
          checks++;
          if (obs[d].rvalid[1] !== 1'b1 || obs[d].err[1] !== 1'b0 || obs[d].rdata1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p1_load_data dut%0d: rvalid %b err %b rdata %h want 1 0 deadbeef",
                     d, obs[d].rvalid[1], obs[d].err[1], obs[d].rdata1);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_misaligned();
    view_t exp_v;
    for (int step = 0; step < 4; step++) begin
      idle_all();
      for (int d = 0; d < 2; d++) begin
        if (step == 0) set_req(d, 1, 1'b1, 11'h010, 32'h0000ABCD, 4'b1111);
        if (step == 1) set_req(d, 1, 1'b1, 11'h011, 32'hFFFFFFFF, 4'b0011);
        if (step == 2) set_req(d, 1, 1'b0, 11'h010, 32'h0, 4'b1111);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_v = model_view(d);
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL misaligned step%0d dut%0d: got %h want %h", step, d, obs[d], exp_v);
        end
        checks++;
        if (step == 1 && (obs[d].mem_wren !== 1'b0 || obs[d].gnt !== 2'b10)) begin
          errors++;
          $display("FAIL illegal_no_write dut%0d: wren %b gnt %b want 0 10", d, obs[d].mem_wren, obs[d].gnt);
        end else if (step == 2 && (obs[d].err[1] !== 1'b1 || obs[d].rdata1 !== 32'h0)) begin
          errors++;
          $display("FAIL illegal_err dut%0d: err %b rdata %h want 1 0", d, obs[d].err[1], obs[d].rdata1);
        end else if (step == 3 && obs[d].rdata1 !== 32'h0000ABCD) begin
          errors++;
          $display("FAIL prior_value dut%0d: rdata %h want 0000abcd", d, obs[d].rdata1);
        end
      end
      advance();
    end
  endtask

  task automatic test_arbitration();
    view_t      exp_v;
    logic [1:0] want [2];
    int         w [2];
    idle_all();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 11'(4 * $urandom_range(0, 15)), 32'h0, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      want[0] = (i % 2 == 0) ? 2'b01 : 2'b10;
      want[1] = (i % 5 == 4) ? 2'b10 : 2'b01;
      for (int d = 0; d < 2; d++) begin
        exp_v = model_view(d);
        w[d]  = winner(d);
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL arb_cycle%0d dut%0d: got %h want %h", i, d, obs[d], exp_v);
        end
        checks++;
        if (obs[d].gnt !== want[d]) begin
          errors++;
          $display("FAIL arb_pattern%0d dut%0d: gnt %b want %b", i, d, obs[d].gnt, want[d]);
        end
      end
      advance();
      for (int d = 0; d < 2; d++)
        if (w[d] >= 0) set_req(d, w[d], 1'b0, 11'(4 * $urandom_range(0, 15)), 32'h0, 4'b1111);
    end
    idle_all();
  endtask

  task automatic test_reset_cancel();
    view_t exp_v;
    for (int step = 0; step < 4; step++) begin
      idle_all();
      rst = (step == 1);
      for (int d = 0; d < 2; d++) begin
        if (step == 0) set_req(d, 0, 1'b0, 11'h00C, 32'h0, 4'b1111);
        if (step == 2) begin
          set_req(d, 0, 1'b0, 11'h004, 32'h0, 4'b1111);
          set_req(d, 1, 1'b0, 11'h008, 32'h0, 4'b1111);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_v = model_view(d);
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL reset_cancel step%0d dut%0d: got %h want %h", step, d, obs[d], exp_v);
        end
        checks++;
        if (step == 1 && obs[d].rvalid !== 2'b00) begin
          errors++;
          $display("FAIL pending_discard dut%0d: rvalid %b want 00", d, obs[d].rvalid);
        end else if (step == 2 && obs[d].gnt !== 2'b01) begin
          errors++;
          $display("FAIL pointer_restore dut%0d: gnt %b want 01", d, obs[d].gnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    view_t exp_v;
    int    w [2];
    idle_all();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_v = model_view(d);
        w[d]  = winner(d);
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL random_cycle%0d dut%0d: got %h want %h", i, d, obs[d], exp_v);
        end
      end
      advance();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 63) == 0) rst = 1'b1;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          if (drv[d][p].req) begin
            if (w[d] == p) drv[d][p] = ($urandom_range(0, 1) == 1) ? rand_req() : '0;
            else if ($urandom_range(0, 15) == 0) drv[d][p] = '0;
          end else if ($urandom_range(0, 1) == 1) begin
            drv[d][p] = rand_req();
          end
        end
    end
    idle_all();
    rst = 1'b0;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) model_tick(d);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_misaligned();
    test_arbitration();
    test_reset_cancel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
